// File: rtl/mac_pkg.sv
// Shared types and sizing for the MAC pre-sequencer slice.
package mac_pkg;

    localparam int unsigned MAC_N_LANE = 64;
    localparam int unsigned MAC_W_BEAT = 640;

    typedef struct packed {
        logic [5:0]  lane_cnt;
        logic [15:0] ifm_beats;
    } mac_seq_instruction_port;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_WFM,
        STREAM_IFM,
        DONE
    } mac_seq_state_e;

endpackage

// File: rtl/mac_seq_pipe_reg.sv
// One-entry ready/valid register; accepts a new beat whenever it is empty or draining.
module mac_seq_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign o_ready = !valid_q || i_ready;
    assign o_valid = valid_q;
    assign o_data  = data_q;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (i_valid && o_ready) begin
            valid_d = 1'b1;
            data_d  = i_data;
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/mac_pre_sequencer.sv
// Per instruction: loads one WFM beat per lane via a one-hot strobe, then broadcasts
// a counted IFM burst to all lanes and raises done until it is accepted.
module mac_pre_sequencer
    import mac_pkg::*;
#(
    parameter int unsigned N_LANE = MAC_N_LANE,
    parameter int unsigned W_DATA = MAC_W_BEAT
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    output logic                    o_instruction_ready,
    input  logic                    i_instruction_valid,
    input  mac_seq_instruction_port i_instruction,
    output logic                    o_done,
    input  logic                    i_done_ready,
    input  logic                    i_wfm_valid,
    output logic                    o_wfm_ready,
    input  logic [W_DATA-1:0]       i_wfm,
    input  logic                    i_ifm_valid,
    output logic                    o_ifm_ready,
    input  logic [W_DATA-1:0]       i_ifm,
    output logic [N_LANE-1:0]       o_lane_wfm_valid,
    output logic [W_DATA-1:0]       o_lane_wfm,
    input  logic                    i_lane_ifm_ready,
    output logic                    o_lane_ifm_valid,
    output logic [W_DATA-1:0]       o_lane_ifm,
    output logic                    o_lane_ifm_last
);

    mac_seq_state_e    state_q;
    logic [5:0]        lane_cnt_q;
    logic [5:0]        lane_idx_q;
    logic [15:0]       ifm_beats_q;
    logic [16:0]       in_cnt_q;
    logic [N_LANE-1:0] lane_wfm_valid_q;
    logic [W_DATA-1:0] lane_wfm_q;
    logic              done_q;

    logic              pipe_in_ready;
    logic              in_room;
    logic              ifm_acc;
    logic              out_hs;
    logic              ifm_last_in;
    logic [W_DATA:0]   pipe_out;

    // in_cnt is one bit wider than ifm_beats so the final beat of a 65536-beat burst still fits
    assign in_room     = in_cnt_q <= {1'b0, ifm_beats_q};
    assign ifm_last_in = in_cnt_q == {1'b0, ifm_beats_q};

    assign o_instruction_ready = i_reset && (state_q == IDLE);
    assign o_wfm_ready         = i_reset && (state_q == LOAD_WFM);
    assign o_ifm_ready         = i_reset && (state_q == STREAM_IFM) && in_room && pipe_in_ready;

    assign ifm_acc = i_ifm_valid && o_ifm_ready;
    assign out_hs  = o_lane_ifm_valid && i_lane_ifm_ready;

    assign o_lane_wfm_valid = lane_wfm_valid_q;
    assign o_lane_wfm       = lane_wfm_q;
    assign o_done           = done_q;
    assign o_lane_ifm_last  = pipe_out[W_DATA];
    assign o_lane_ifm       = pipe_out[W_DATA-1:0];

    mac_seq_pipe_reg #(
        .W (W_DATA + 1)
    ) u_ifm_reg (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_valid (ifm_acc),
        .o_ready (pipe_in_ready),
        .i_data  ({ifm_last_in, i_ifm}),
        .o_valid (o_lane_ifm_valid),
        .o_data  (pipe_out),
        .i_ready (i_lane_ifm_ready)
    );

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q          <= IDLE;
            lane_cnt_q       <= '0;
            lane_idx_q       <= '0;
            ifm_beats_q      <= '0;
            in_cnt_q         <= '0;
            lane_wfm_valid_q <= '0;
            lane_wfm_q       <= '0;
            done_q           <= 1'b0;
        end else begin
            lane_wfm_valid_q <= '0;
            case (state_q)
                IDLE: begin
                    if (i_instruction_valid) begin
                        lane_cnt_q  <= i_instruction.lane_cnt;
                        ifm_beats_q <= i_instruction.ifm_beats;
                        lane_idx_q  <= '0;
                        in_cnt_q    <= '0;
                        state_q     <= LOAD_WFM;
                    end
                end
                LOAD_WFM: begin
                    if (i_wfm_valid) begin
                        lane_wfm_valid_q <= {{(N_LANE-1){1'b0}}, 1'b1} << lane_idx_q;
                        lane_wfm_q       <= i_wfm;
                        if (lane_idx_q == lane_cnt_q) begin
                            state_q <= STREAM_IFM;
                        end else begin
                            lane_idx_q <= lane_idx_q + 6'd1;
                        end
                    end
                end
                STREAM_IFM: begin
                    if (ifm_acc) begin
                        in_cnt_q <= in_cnt_q + 17'd1;
                    end
                    if (out_hs && o_lane_ifm_last) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (i_done_ready) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_pre_sequencer.sv
// Directed bench for mac_pre_sequencer: a per-cycle vector table plus hand-written corner sequences.
module tb_mac_pre_sequencer;
    import mac_pkg::*;

    localparam int unsigned W = MAC_W_BEAT;
    localparam int unsigned N = MAC_N_LANE;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    ir, iv, done, dr, wv, wr, fv, fr, lr, liv, last;
    mac_seq_instruction_port instr;
    logic [W-1:0]            wfm, ifm, lw, li;
    logic [N-1:0]            lwv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mac_pre_sequencer #(
        .N_LANE (N),
        .W_DATA (W)
    ) dut (
        .i_clk               (clk),
        .i_reset             (rst_n),
        .o_instruction_ready (ir),
        .i_instruction_valid (iv),
        .i_instruction       (instr),
        .o_done              (done),
        .i_done_ready        (dr),
        .i_wfm_valid         (wv),
        .o_wfm_ready         (wr),
        .i_wfm               (wfm),
        .i_ifm_valid         (fv),
        .o_ifm_ready         (fr),
        .i_ifm               (ifm),
        .o_lane_wfm_valid    (lwv),
        .o_lane_wfm          (lw),
        .i_lane_ifm_ready    (lr),
        .o_lane_ifm_valid    (liv),
        .o_lane_ifm          (li),
        .o_lane_ifm_last     (last)
    );

    function automatic logic [W-1:0] mk(input logic [15:0] t);
        return {40{t}};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic chkd(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual(lo64)=%h expected(lo64)=%h", name, act[63:0], exp[63:0]);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        iv = 1'b0; instr = '0; wv = 1'b0; wfm = '0; fv = 1'b0; ifm = '0; lr = 1'b0; dr = 1'b1;
    endtask

    typedef struct {
        logic        iv; logic [5:0] lc; logic [15:0] nb;
        logic        wv; logic [15:0] wt;
        logic        fv; logic [15:0] ft;
        logic        lr; logic        dr;
        logic        e_ir, e_wr, e_fr;
        logic [63:0] e_lwv; logic [15:0] e_lwt;
        logic        e_liv; logic [15:0] e_lit; logic e_last;
        logic        e_done;
    } vec_t;

    vec_t tbl[10];

    logic [63:0]  one64;
    logic [W-1:0] prev_data;
    int           sent, recv;
    logic         seen, prev_stall, acc;

    initial begin
        // lane_cnt=3, ifm_beats=1: WFM A..D to lanes 0..3, IFM E,F with last on F, extra G stays upstream
        tbl[0] = '{1, 3, 1, 0, 0,      0, 0,      1, 1,  1, 0, 0,  64'h0, 0,     0, 0,     0,  0};
        tbl[1] = '{0, 0, 0, 1, 'hA,    0, 0,      1, 1,  0, 1, 0,  64'h0, 0,     0, 0,     0,  0};
        tbl[2] = '{0, 0, 0, 1, 'hB,    0, 0,      1, 1,  0, 1, 0,  64'h1, 'hA,   0, 0,     0,  0};
        tbl[3] = '{0, 0, 0, 1, 'hC,    0, 0,      1, 1,  0, 1, 0,  64'h2, 'hB,   0, 0,     0,  0};
        tbl[4] = '{0, 0, 0, 1, 'hD,    0, 0,      1, 1,  0, 1, 0,  64'h4, 'hC,   0, 0,     0,  0};
        tbl[5] = '{0, 0, 0, 0, 0,      1, 'hE,    1, 1,  0, 0, 1,  64'h8, 'hD,   0, 0,     0,  0};
        tbl[6] = '{0, 0, 0, 0, 0,      1, 'hF,    1, 1,  0, 0, 1,  64'h0, 0,     1, 'hE,   0,  0};
        tbl[7] = '{0, 0, 0, 0, 0,      1, 'h10,   1, 1,  0, 0, 0,  64'h0, 0,     1, 'hF,   1,  0};
        tbl[8] = '{0, 0, 0, 0, 0,      0, 0,      1, 1,  0, 0, 0,  64'h0, 0,     0, 0,     0,  1};
        tbl[9] = '{0, 0, 0, 0, 0,      0, 0,      1, 1,  1, 0, 0,  64'h0, 0,     0, 0,     0,  0};

        quiet();
        rst_n = 1'b0;
        repeat (3) next();
        chk("rst_instr_ready", 64'(ir), 64'd0);
        chk("rst_wfm_ready", 64'(wr), 64'd0);
        chk("rst_ifm_ready", 64'(fr), 64'd0);
        chk("rst_lane_wfm_valid", 64'(lwv), 64'd0);
        chk("rst_lane_ifm_valid", 64'(liv), 64'd0);
        chk("rst_last", 64'(last), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chkd("rst_lane_wfm", lw, '0);
        chkd("rst_lane_ifm", li, '0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_instr_ready", 64'(ir), 64'd1);

        for (int i = 0; i < 10; i++) begin
            iv = tbl[i].iv; instr.lane_cnt = tbl[i].lc; instr.ifm_beats = tbl[i].nb;
            wv = tbl[i].wv; wfm = mk(tbl[i].wt); fv = tbl[i].fv; ifm = mk(tbl[i].ft);
            lr = tbl[i].lr; dr = tbl[i].dr;
            #1;
            chk($sformatf("v%0d_instr_ready", i), 64'(ir), 64'(tbl[i].e_ir));
            chk($sformatf("v%0d_wfm_ready", i), 64'(wr), 64'(tbl[i].e_wr));
            chk($sformatf("v%0d_ifm_ready", i), 64'(fr), 64'(tbl[i].e_fr));
            chk($sformatf("v%0d_lane_wfm_valid", i), 64'(lwv), tbl[i].e_lwv);
            if (tbl[i].e_lwv != 64'h0) chkd($sformatf("v%0d_lane_wfm", i), lw, mk(tbl[i].e_lwt));
            chk($sformatf("v%0d_lane_ifm_valid", i), 64'(liv), 64'(tbl[i].e_liv));
            if (tbl[i].e_liv) begin
                chkd($sformatf("v%0d_lane_ifm", i), li, mk(tbl[i].e_lit));
                chk($sformatf("v%0d_last", i), 64'(last), 64'(tbl[i].e_last));
            end
            chk($sformatf("v%0d_done", i), 64'(done), 64'(tbl[i].e_done));
            next();
        end
        quiet();

        // lane_cnt=63, ifm_beats=0 with IFM offered during load and WFM offered during stream
        iv = 1'b1; instr.lane_cnt = 6'd63; instr.ifm_beats = 16'd0;
        #1;
        chk("t2_instr_ready", 64'(ir), 64'd1);
        next();
        iv = 1'b0;
        one64 = 64'd1;
        for (int k = 0; k < 64; k++) begin
            wv = 1'b1; wfm = mk(16'h100 + 16'(k)); fv = 1'b1; ifm = mk(16'h7777); lr = 1'b0;
            #1;
            chk($sformatf("t2_wfm_ready_%0d", k), 64'(wr), 64'd1);
            chk($sformatf("t2_ifm_gated_%0d", k), 64'(fr), 64'd0);
            chk($sformatf("t2_no_ifm_out_%0d", k), 64'(liv), 64'd0);
            if (k > 0) begin
                chk($sformatf("t2_onehot_%0d", k - 1), 64'(lwv), one64 << (k - 1));
                chkd($sformatf("t2_wfm_data_%0d", k - 1), lw, mk(16'h100 + 16'(k - 1)));
            end else begin
                chk("t2_no_strobe_before_accept", 64'(lwv), 64'd0);
            end
            next();
        end
        wv = 1'b1; wfm = mk(16'hBAD0); fv = 1'b1; ifm = mk(16'h200);
        #1;
        chk("t2_onehot_63", 64'(lwv), one64 << 63);
        chkd("t2_wfm_data_63", lw, mk(16'h13F));
        chk("t2_wfm_gated_stream", 64'(wr), 64'd0);
        chk("t2_first_ifm_ready", 64'(fr), 64'd1);
        next();
        fv = 1'b1; ifm = mk(16'h201);
        for (int s = 0; s < 3; s++) begin
            #1;
            chk($sformatf("t2_wfm_gated_%0d", s), 64'(wr), 64'd0);
            chk($sformatf("t2_no_wrap_strobe_%0d", s), 64'(lwv), 64'd0);
            chk($sformatf("t2_ifm_closed_%0d", s), 64'(fr), 64'd0);
            chk($sformatf("t2_hold_valid_%0d", s), 64'(liv), 64'd1);
            chkd($sformatf("t2_hold_data_%0d", s), li, mk(16'h200));
            chk($sformatf("t2_hold_last_%0d", s), 64'(last), 64'd1);
            next();
        end
        wv = 1'b0; fv = 1'b0; lr = 1'b1; dr = 1'b0;
        #1;
        chk("t2_done_not_yet", 64'(done), 64'd0);
        next();
        lr = 1'b0;

        // done held while i_done_ready=0
        for (int s = 0; s < 5; s++) begin
            #1;
            chk($sformatf("t5_done_held_%0d", s), 64'(done), 64'd1);
            chk($sformatf("t5_instr_blocked_%0d", s), 64'(ir), 64'd0);
            chk($sformatf("t5_lane_ifm_idle_%0d", s), 64'(liv), 64'd0);
            next();
        end
        dr = 1'b1;
        #1;
        chk("t5_done_at_accept", 64'(done), 64'd1);
        next();
        iv = 1'b1; instr.lane_cnt = 6'd0; instr.ifm_beats = 16'd9;
        #1;
        chk("t5_instr_ready_after_done", 64'(ir), 64'd1);
        chk("t5_done_cleared", 64'(done), 64'd0);
        next();
        iv = 1'b0;

        // ifm_beats=9 with lane ready toggling: order, stability, no bubbles, exactly 10 beats
        wv = 1'b1; wfm = mk(16'h300);
        #1;
        chk("t3_wfm_ready", 64'(wr), 64'd1);
        next();
        wv = 1'b0;
        sent = 0; recv = 0; seen = 1'b0; prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 80 && recv < 10; c++) begin
            logic [8:0] pat;
            pat = 9'b111001011;
            fv = 1'b1; ifm = mk(16'h400 + 16'(sent)); lr = pat[c % 9];
            #1;
            chk($sformatf("t3_ifm_ready_c%0d", c), 64'(fr), 64'((sent < 10) && (!liv || lr)));
            if (prev_stall) chkd($sformatf("t3_stable_c%0d", c), li, prev_data);
            if (seen) chk($sformatf("t3_no_bubble_c%0d", c), 64'(liv), 64'd1);
            if (liv) seen = 1'b1;
            if (liv && lr) begin
                chkd($sformatf("t3_beat_%0d", recv), li, mk(16'h400 + 16'(recv)));
                chk($sformatf("t3_last_%0d", recv), 64'(last), 64'(recv == 9));
                recv++;
            end
            prev_stall = liv && !lr;
            prev_data  = li;
            acc = fr;
            next();
            if (acc) sent++;
        end
        chk("t3_beats_out", 64'(recv), 64'd10);
        chk("t3_beats_taken", 64'(sent), 64'd10);
        chk("t3_done", 64'(done), 64'd1);
        chk("t3_extra_ifm_gated", 64'(fr), 64'd0);
        next();
        fv = 1'b0; lr = 1'b0;
        #1;
        chk("t3_back_idle", 64'(ir), 64'd1);

        // reset while streaming (3 of 8 beats drained), then a clean instruction
        iv = 1'b1; instr.lane_cnt = 6'd0; instr.ifm_beats = 16'd7;
        next();
        iv = 1'b0; wv = 1'b1; wfm = mk(16'h500);
        next();
        wv = 1'b0; recv = 0; sent = 0;
        for (int c = 0; c < 20 && recv < 3; c++) begin
            fv = 1'b1; ifm = mk(16'h600 + 16'(sent)); lr = 1'b1;
            #1;
            if (liv && lr) recv++;
            acc = fr;
            next();
            if (acc) sent++;
        end
        chk("t6_drained_three", 64'(recv), 64'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_inrst_instr_ready", 64'(ir), 64'd0);
        chk("t6_inrst_wfm_ready", 64'(wr), 64'd0);
        chk("t6_inrst_ifm_ready", 64'(fr), 64'd0);
        next();
        chk("t6_rst_lane_ifm_valid", 64'(liv), 64'd0);
        chk("t6_rst_lane_wfm_valid", 64'(lwv), 64'd0);
        chk("t6_rst_done", 64'(done), 64'd0);
        chk("t6_rst_last", 64'(last), 64'd0);
        chkd("t6_rst_lane_ifm", li, '0);
        chkd("t6_rst_lane_wfm", lw, '0);
        rst_n = 1'b1; quiet();
        iv = 1'b1; instr.lane_cnt = 6'd1; instr.ifm_beats = 16'd1;
        #1;
        chk("t6_instr_ready_after_rst", 64'(ir), 64'd1);
        next();
        iv = 1'b0; wv = 1'b1; wfm = mk(16'h700);
        next();
        wfm = mk(16'h701);
        #1;
        chk("t6_lane0_strobe", 64'(lwv), 64'h1);
        next();
        wv = 1'b0; fv = 1'b1; ifm = mk(16'h710); lr = 1'b1;
        #1;
        chk("t6_lane1_strobe", 64'(lwv), 64'h2);
        chkd("t6_lane1_data", lw, mk(16'h701));
        next();
        ifm = mk(16'h711);
        #1;
        chkd("t6_ifm0", li, mk(16'h710));
        chk("t6_ifm0_last", 64'(last), 64'd0);
        next();
        fv = 1'b0;
        #1;
        chkd("t6_ifm1", li, mk(16'h711));
        chk("t6_ifm1_last", 64'(last), 64'd1);
        next();
        #1;
        chk("t6_done", 64'(done), 64'd1);
        next();
        #1;
        chk("t6_idle_again", 64'(ir), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d checks", checks);
        $fatal(1, "timeout");
    end

endmodule
